// File: rtl/oci_dtrace_packer.sv
// Data-trace packer: packs 2-bit debug fragments into 30-bit trace words and sequences end-of-test.
// Optional macro OCI_DTRACE_DROP_CNT_EN adds a saturating drop_count output for discarded fragments.
module oci_dtrace_packer #(
  parameter int FRAGS_PER_WORD = 15,
  parameter bit DROP_WHEN_BUSY = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frag_valid,
  input  logic [1:0]  frag_data,
  output logic        frag_ready,
  input  logic        flush,
  input  logic        end_req,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        dct_valid,
  input  logic        dct_ready,
  output logic        test_ending,
  output logic        test_has_ended,
  output logic [1:0]  dbg_state
`ifdef OCI_DTRACE_DROP_CNT_EN
  ,
  output logic [15:0] drop_count
`endif
);

  // Handshakes: a fragment moves when frag_valid & frag_ready, a word when dct_valid & dct_ready,
  // both on the rising clk edge; valid never waits on ready.

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_ENDING = 2'd1,
    ST_ENDED  = 2'd2
  } state_t;

  localparam logic [3:0] FULL_CNT = 4'(FRAGS_PER_WORD);
  localparam logic [3:0] LAST_CNT = 4'(FRAGS_PER_WORD - 1);

  state_t      state_q, state_d;
  logic [29:0] acc_q, acc_d;
  logic [3:0]  acc_cnt_q, acc_cnt_d;
  logic        flush_pend_q, flush_pend_d;
  logic [29:0] dct_buffer_q, dct_buffer_d;
  logic [3:0]  dct_count_q, dct_count_d;
  logic        dct_valid_q, dct_valid_d;
  logic        test_ending_q, test_ending_d;
  logic        test_has_ended_q, test_has_ended_d;
  logic        take_ok;
  logic        accept;
  logic [29:0] packed_word;

  always_comb begin
    // The final fragment of a word is held off while the previous word is still unclaimed.
    take_ok = (state_q == ST_RUN) && !flush_pend_q &&
              !((acc_cnt_q == LAST_CNT) && dct_valid_q);
    accept      = frag_valid && take_ok;
    packed_word = {acc_q[27:0], frag_data};

    state_d          = state_q;
    acc_d            = acc_q;
    acc_cnt_d        = acc_cnt_q;
    flush_pend_d     = flush_pend_q;
    dct_buffer_d     = dct_buffer_q;
    dct_count_d      = dct_count_q;
    dct_valid_d      = dct_valid_q;
    test_ending_d    = test_ending_q;
    test_has_ended_d = test_has_ended_q;

    if (dct_valid_q && dct_ready) begin
      dct_valid_d = 1'b0;
    end

    if (accept) begin
      if (acc_cnt_q == LAST_CNT) begin
        dct_buffer_d = packed_word;
        dct_count_d  = FULL_CNT;
        dct_valid_d  = 1'b1;
        acc_d        = '0;
        acc_cnt_d    = '0;
      end else begin
        acc_d     = packed_word;
        acc_cnt_d = acc_cnt_q + 4'd1;
      end
    end else if (flush_pend_q && !dct_valid_q) begin
      if (acc_cnt_q != 4'd0) begin
        dct_buffer_d = acc_q;
        dct_count_d  = acc_cnt_q;
        dct_valid_d  = 1'b1;
        acc_d        = '0;
        acc_cnt_d    = '0;
      end
      flush_pend_d = 1'b0;
    end

    case (state_q)
      ST_RUN: begin
        if (end_req) begin
          state_d       = ST_ENDING;
          test_ending_d = 1'b1;
          flush_pend_d  = 1'b1;
        end else if (flush) begin
          flush_pend_d = 1'b1;
        end
      end
      ST_ENDING: begin
        if (!flush_pend_q && !dct_valid_q) begin
          state_d          = ST_ENDED;
          test_has_ended_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_ENDED;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= ST_RUN;
      acc_q            <= '0;
      acc_cnt_q        <= '0;
      flush_pend_q     <= 1'b0;
      dct_buffer_q     <= '0;
      dct_count_q      <= '0;
      dct_valid_q      <= 1'b0;
      test_ending_q    <= 1'b0;
      test_has_ended_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      acc_q            <= acc_d;
      acc_cnt_q        <= acc_cnt_d;
      flush_pend_q     <= flush_pend_d;
      dct_buffer_q     <= dct_buffer_d;
      dct_count_q      <= dct_count_d;
      dct_valid_q      <= dct_valid_d;
      test_ending_q    <= test_ending_d;
      test_has_ended_q <= test_has_ended_d;
    end
  end

`ifdef OCI_DTRACE_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        discard;

  always_comb begin
    discard    = DROP_WHEN_BUSY && frag_valid && !take_ok && (state_q != ST_ENDED);
    drop_cnt_d = drop_cnt_q;
    if (discard && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count = drop_cnt_q;
`endif

  assign frag_ready     = DROP_WHEN_BUSY ? 1'b1 : take_ok;
  assign dct_buffer     = dct_buffer_q;
  assign dct_count      = dct_count_q;
  assign dct_valid      = dct_valid_q;
  assign test_ending    = test_ending_q;
  assign test_has_ended = test_has_ended_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_oci_dtrace_packer.sv
// Self-checking bench for oci_dtrace_packer: a back-pressured instance and a drop-when-busy instance.
module tb_oci_dtrace_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        frag_valid, flush, end_req, dct_ready;
  logic [1:0]  frag_data;
  logic        frag_ready, dct_valid, test_ending, test_has_ended;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic [1:0]  dbg_state;

  logic        d_frag_valid, d_flush, d_end_req, d_dct_ready;
  logic [1:0]  d_frag_data;
  logic        d_frag_ready, d_dct_valid, d_test_ending, d_test_has_ended;
  logic [29:0] d_dct_buffer;
  logic [3:0]  d_dct_count;
  logic [1:0]  d_dbg_state;
`ifdef OCI_DTRACE_DROP_CNT_EN
  logic [15:0] drop_count, d_drop_count;
`endif

  oci_dtrace_packer #(.FRAGS_PER_WORD(15), .DROP_WHEN_BUSY(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .frag_valid(frag_valid), .frag_data(frag_data),
    .frag_ready(frag_ready), .flush(flush), .end_req(end_req), .dct_buffer(dct_buffer),
    .dct_count(dct_count), .dct_valid(dct_valid), .dct_ready(dct_ready),
    .test_ending(test_ending), .test_has_ended(test_has_ended), .dbg_state(dbg_state)
`ifdef OCI_DTRACE_DROP_CNT_EN
    , .drop_count(drop_count)
`endif
  );

  oci_dtrace_packer #(.FRAGS_PER_WORD(15), .DROP_WHEN_BUSY(1'b1)) dut_drop (
    .clk(clk), .reset_n(reset_n), .frag_valid(d_frag_valid), .frag_data(d_frag_data),
    .frag_ready(d_frag_ready), .flush(d_flush), .end_req(d_end_req), .dct_buffer(d_dct_buffer),
    .dct_count(d_dct_count), .dct_valid(d_dct_valid), .dct_ready(d_dct_ready),
    .test_ending(d_test_ending), .test_has_ended(d_test_has_ended), .dbg_state(d_dbg_state)
`ifdef OCI_DTRACE_DROP_CNT_EN
    , .drop_count(d_drop_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [29:0] exp_q[$];
  logic [3:0]  exp_cnt_q[$];
  logic [1:0]  pend_q[$];

  function automatic logic [29:0] pack_frags(input logic [1:0] f[$]);
    logic [29:0] w;
    w = '0;
    foreach (f[i]) w = w * 30'd4 + 30'(f[i]);
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    frag_valid = 0; frag_data = 0; flush = 0; end_req = 0; dct_ready = 0;
    d_frag_valid = 0; d_frag_data = 0; d_flush = 0; d_end_req = 0; d_dct_ready = 0;
    reset_n = 0;
    exp_q.delete(); exp_cnt_q.delete(); pend_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({dct_valid, dct_buffer, dct_count, test_ending, test_has_ended, frag_ready} !==
        {1'b0, 30'h0, 4'h0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_outputs: got v=%0b buf=%h cnt=%0d end=%0b ended=%0b fr=%0b, want 0/0/0/0/0/1",
               dct_valid, dct_buffer, dct_count, test_ending, test_has_ended, frag_ready);
    end
  endtask

  task automatic test_full_word();
    do_reset();
    dct_ready = 1;
    for (int i = 0; i < 15; i++) begin
      frag_valid = 1; frag_data = 2'b01;
      tick();
      if (i == 13) begin
        checks++;
        if (dct_valid !== 1'b0) begin
          errors++;
          $display("FAIL full_early_valid: got %0b want 0", dct_valid);
        end
      end
    end
    frag_valid = 0;
    checks++;
    if ({dct_valid, dct_buffer, dct_count} !== {1'b1, 30'h15555555, 4'd15}) begin
      errors++;
      $display("FAIL full_word: got v=%0b buf=%h cnt=%0d want 1/15555555/15", dct_valid, dct_buffer, dct_count);
    end
    checks++;
    if (dut.acc_cnt_q !== 4'd0) begin
      errors++;
      $display("FAIL full_acc_cnt: got %0d want 0", dut.acc_cnt_q);
    end
    tick();
    checks++;
    if (dct_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_handshake_clear: got %0b want 0", dct_valid);
    end
  endtask

  task automatic test_flush();
    logic bad;
    logic [1:0] seq [3];
    int waited;
    seq[0] = 2'b11; seq[1] = 2'b10; seq[2] = 2'b01;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      frag_valid = 1; frag_data = seq[i];
      tick();
    end
    frag_valid = 0; flush = 1;
    tick();
    flush = 0;
    tick();
    checks++;
    if ({dct_valid, dct_buffer, dct_count} !== {1'b1, 30'h39, 4'd3}) begin
      errors++;
      $display("FAIL flush_partial: got v=%0b buf=%h cnt=%0d want 1/39/3", dct_valid, dct_buffer, dct_count);
    end
    dct_ready = 1;
    tick();
    flush = 1;
    tick();
    flush = 0;
    bad = 0;
    repeat (5) begin
      tick();
      if (dct_valid !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL flush_empty: got a word, want none");
    end
    checks++;
    if (frag_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_empty_ready: got %0b want 1", frag_ready);
    end
    // fragment accepted alongside the flush pulse joins the flushed word
    frag_valid = 1; frag_data = 2'b10;
    tick();
    frag_data = 2'b01; flush = 1;
    tick();
    frag_valid = 0; flush = 0; dct_ready = 0;
    waited = 0;
    while (dct_valid !== 1'b1 && waited < 6) begin
      tick();
      waited++;
    end
    checks++;
    if ({dct_valid, dct_buffer, dct_count} !== {1'b1, 30'h9, 4'd2}) begin
      errors++;
      $display("FAIL flush_same_cycle: got v=%0b buf=%h cnt=%0d want 1/9/2", dct_valid, dct_buffer, dct_count);
    end
  endtask

  task automatic test_backpressure();
    int accepts, words;
    logic seen, unstable;
    logic [29:0] held, last_w;
    logic [3:0] last_c;
    do_reset();
    frag_data = 2'b10;
    frag_valid = 1;
    accepts = 0; seen = 0; unstable = 0; held = '0;
    for (int c = 0; c < 40; c++) begin
      if (frag_valid && frag_ready) accepts++;
      tick();
      if (dct_valid) begin
        if (seen && dct_buffer !== held) unstable = 1;
        seen = 1; held = dct_buffer;
      end
    end
    checks++;
    if (accepts != 29) begin
      errors++;
      $display("FAIL bp_accepts: got %0d want 29", accepts);
    end
    checks++;
    if ({frag_ready, dct_valid, dct_buffer, dct_count, unstable} !== {1'b0, 1'b1, 30'h2AAAAAAA, 4'd15, 1'b0}) begin
      errors++;
      $display("FAIL bp_held: got fr=%0b v=%0b buf=%h cnt=%0d unstable=%0b want 0/1/2aaaaaaa/15/0",
               frag_ready, dct_valid, dct_buffer, dct_count, unstable);
    end
    dct_ready = 1;
    words = 0; last_w = '0; last_c = '0;
    for (int c = 0; c < 10; c++) begin
      if (dct_valid && dct_ready) begin
        words++; last_w = dct_buffer; last_c = dct_count;
      end
      if (frag_valid && frag_ready) accepts++;
      tick();
      if (accepts == 30) frag_valid = 0;
    end
    checks++;
    if (words != 2 || last_w !== 30'h2AAAAAAA || last_c !== 4'd15) begin
      errors++;
      $display("FAIL bp_second_word: got words=%0d buf=%h cnt=%0d want 2/2aaaaaaa/15", words, last_w, last_c);
    end
`ifdef OCI_DTRACE_DROP_CNT_EN
    checks++;
    if (drop_count !== 16'd0) begin
      errors++;
      $display("FAIL bp_drop_count: got %0d want 0", drop_count);
    end
`endif
  endtask

  task automatic test_random();
    logic hold;
    logic [29:0] hold_buf, w;
    logic [3:0] hold_cnt, c;
    do_reset();
    hold = 0; hold_buf = '0; hold_cnt = '0;
    for (int cyc = 0; cyc < 460; cyc++) begin
      if (cyc < 400) begin
        frag_valid = ($urandom_range(0, 9) < 7);
        frag_data  = 2'($urandom_range(0, 3));
        dct_ready  = 1'($urandom_range(0, 1));
        flush      = ($urandom_range(0, 29) == 0);
      end else begin
        frag_valid = 0; dct_ready = 1;
        flush = (cyc == 400);
      end
      if (hold) begin
        checks++;
        if (dct_buffer !== hold_buf || dct_count !== hold_cnt) begin
          errors++;
          $display("FAIL rnd_stable: got %h/%0d want %h/%0d", dct_buffer, dct_count, hold_buf, hold_cnt);
        end
      end
      if (dct_valid && pend_q.size() == 14) begin
        checks++;
        if (frag_ready !== 1'b0) begin
          errors++;
          $display("FAIL rnd_ready_rule: got %0b want 0", frag_ready);
        end
      end
      if (dct_valid && dct_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rnd_unexpected_word: got %h/%0d want none", dct_buffer, dct_count);
        end else begin
          w = exp_q.pop_front(); c = exp_cnt_q.pop_front();
          if (dct_buffer !== w || dct_count !== c) begin
            errors++;
            $display("FAIL rnd_word: got %h/%0d want %h/%0d", dct_buffer, dct_count, w, c);
          end
        end
      end
      hold = dct_valid && !dct_ready;
      hold_buf = dct_buffer; hold_cnt = dct_count;
      if (frag_valid && frag_ready) begin
        pend_q.push_back(frag_data);
        if (pend_q.size() == 15) begin
          exp_q.push_back(pack_frags(pend_q)); exp_cnt_q.push_back(4'd15);
          pend_q.delete();
        end
      end
      if (flush && pend_q.size() > 0) begin
        exp_q.push_back(pack_frags(pend_q)); exp_cnt_q.push_back(4'(pend_q.size()));
        pend_q.delete();
      end
      tick();
    end
    flush = 0;
    checks++;
    if (exp_q.size() != 0 || dct_valid !== 1'b0) begin
      errors++;
      $display("FAIL rnd_drain: got %0d words left, v=%0b, want 0/0", exp_q.size(), dct_valid);
    end
  endtask

  task automatic test_end();
    logic bad;
    int waited;
    logic [29:0] w;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      frag_valid = 1; frag_data = 2'($urandom_range(0, 3));
      pend_q.push_back(frag_data);
      tick();
    end
    w = pack_frags(pend_q);
    frag_valid = 0; end_req = 1;
    tick();
    end_req = 0;
    checks++;
    if ({test_ending, test_has_ended, frag_ready} !== 3'b100) begin
      errors++;
      $display("FAIL end_start: got ending=%0b ended=%0b fr=%0b want 1/0/0", test_ending, test_has_ended, frag_ready);
    end
    waited = 0;
    while (dct_valid !== 1'b1 && waited < 6) begin
      tick();
      waited++;
    end
    checks++;
    if ({dct_valid, dct_buffer, dct_count} !== {1'b1, w, 4'd5}) begin
      errors++;
      $display("FAIL end_partial: got v=%0b buf=%h cnt=%0d want 1/%h/5", dct_valid, dct_buffer, dct_count, w);
    end
    bad = 0;
    repeat (10) begin
      tick();
      if (dct_valid !== 1'b1 || dct_buffer !== w || test_has_ended !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL end_hold: got word change or early end, want held word and ended=0");
    end
    dct_ready = 1;
    tick();
    dct_ready = 0;
    checks++;
    if ({dct_valid, test_has_ended} !== 2'b00) begin
      errors++;
      $display("FAIL end_after_hs: got v=%0b ended=%0b want 0/0", dct_valid, test_has_ended);
    end
    tick();
    checks++;
    if ({test_ending, test_has_ended} !== 2'b11) begin
      errors++;
      $display("FAIL end_done: got ending=%0b ended=%0b want 1/1", test_ending, test_has_ended);
    end
    bad = 0;
    repeat (6) begin
      frag_valid = 1; flush = 1; end_req = 1; dct_ready = 1'($urandom_range(0, 1));
      if (frag_ready !== 1'b0) bad = 1;
      tick();
      if (dct_valid !== 1'b0 || test_ending !== 1'b1 || test_has_ended !== 1'b1) bad = 1;
    end
    frag_valid = 0; flush = 0; end_req = 0; dct_ready = 0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL end_terminal: got activity after end, want none");
    end
  endtask

  task automatic test_reset_mid();
    logic bad;
    do_reset();
    for (int i = 0; i < 22; i++) begin
      frag_valid = 1; frag_data = 2'b11;
      tick();
    end
    frag_valid = 0;
    checks++;
    if (dct_valid !== 1'b1 || dut.acc_cnt_q !== 4'd7) begin
      errors++;
      $display("FAIL rstmid_setup: got v=%0b acc_cnt=%0d want 1/7", dct_valid, dut.acc_cnt_q);
    end
    #2 reset_n = 0;
    #1;
    checks++;
    if ({dct_valid, dct_buffer, dct_count, test_ending, test_has_ended} !== 37'h0) begin
      errors++;
      $display("FAIL rstmid_async: got v=%0b buf=%h cnt=%0d want all 0", dct_valid, dct_buffer, dct_count);
    end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1;
    bad = 0;
    repeat (4) begin
      tick();
      if (dct_valid !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL rstmid_stale_word: got a word after release, want none");
    end
    pend_q.delete();
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      frag_valid = 1; frag_data = 2'($urandom_range(0, 2));
      pend_q.push_back(frag_data);
      tick();
      if (i < 14 && dct_valid !== 1'b0) bad = 1;
    end
    frag_valid = 0;
    checks++;
    if (bad || {dct_valid, dct_buffer, dct_count} !== {1'b1, pack_frags(pend_q), 4'd15}) begin
      errors++;
      $display("FAIL rstmid_fresh: got early=%0b v=%0b buf=%h cnt=%0d want 0/1/%h/15",
               bad, dct_valid, dct_buffer, dct_count, pack_frags(pend_q));
    end
  endtask

  task automatic test_drop();
    logic bad;
    logic [29:0] w1;
    do_reset();
    bad = 0;
    for (int i = 0; i < 35; i++) begin
      d_frag_valid = 1; d_frag_data = 2'($urandom_range(0, 3));
      if (d_frag_ready !== 1'b1) bad = 1;
      if (i < 29) pend_q.push_back(d_frag_data);
      tick();
    end
    d_frag_valid = 0;
    w1 = pack_frags(pend_q[0:14]);
    pend_q = pend_q[15:$];
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL drop_ready: got frag_ready low, want always 1");
    end
    checks++;
    if ({d_dct_valid, d_dct_buffer, d_dct_count} !== {1'b1, w1, 4'd15}) begin
      errors++;
      $display("FAIL drop_first_word: got v=%0b buf=%h cnt=%0d want 1/%h/15", d_dct_valid, d_dct_buffer, d_dct_count, w1);
    end
`ifdef OCI_DTRACE_DROP_CNT_EN
    checks++;
    if (d_drop_count !== 16'd6) begin
      errors++;
      $display("FAIL drop_count: got %0d want 6", d_drop_count);
    end
`endif
    d_dct_ready = 1;
    tick();
    d_dct_ready = 0;
    d_frag_valid = 1; d_frag_data = 2'b01;
    pend_q.push_back(2'b01);
    tick();
    d_frag_valid = 0;
    checks++;
    if ({d_dct_valid, d_dct_buffer, d_dct_count} !== {1'b1, pack_frags(pend_q), 4'd15}) begin
      errors++;
      $display("FAIL drop_second_word: got v=%0b buf=%h cnt=%0d want 1/%h/15",
               d_dct_valid, d_dct_buffer, d_dct_count, pack_frags(pend_q));
    end
`ifdef OCI_DTRACE_DROP_CNT_EN
    checks++;
    if (d_drop_count !== 16'd6) begin
      errors++;
      $display("FAIL drop_count_hold: got %0d want 6", d_drop_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_flush();
    test_backpressure();
    test_random();
    test_end();
    test_reset_mid();
    test_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
